// File: rtl/uart_rx_fsm_cfg.sv
// uart_rx_fsm_cfg: oversampled UART receiver. Each bit is decided by a
// 3-sample majority vote around mid-bit; parity mode is latched per character
// and parity, framing and break status are reported with every character.
module uart_rx_fsm_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic                 sample_tick,
    input  logic [1:0]           parity_mode,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] MID_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] MID    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] MID_P1 = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] NBITS  = BW'(DATA_BITS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        STOP2
    } state_t;

    // Majority of three samples; one corrupted sample cannot flip the bit.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                 rx_meta_q;
    logic                 rx_s_q;
    state_t               state_q;
    logic [TW-1:0]        tick_q;
    logic [BW-1:0]        bit_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [1:0]           par_q;
    logic [1:0]           samp_q;
    logic                 pbit_q;
    logic                 perr_q;
    logic                 wait_hi_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 parity_err_q;
    logic                 frame_err_q;
    logic                 break_det_q;

    logic at_vote;
    logic at_wrap;
    logic vote;
    logic par_on;
    logic par_x;
    logic par_bad;
    logic brk;

    assign at_vote = (tick_q == MID_P1);
    assign at_wrap = (tick_q == LAST);
    // samp_q[1] holds the MID-1 sample, samp_q[0] the MID sample.
    assign vote    = maj3(samp_q[1], samp_q[0], rx_s_q);
    // Modes 01 (odd) and 10 (even) enable parity; 00 and 11 disable it.
    assign par_on  = ^par_q;
    assign par_x   = (^shift_q) ^ vote;
    assign par_bad = (par_q == 2'b10) ? par_x : ~par_x;
    // Break: all data bits, the parity bit (if present) and first stop are 0.
    assign brk     = (shift_q == '0) && !(par_on && pbit_q) && !vote;

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;
    assign busy       = (state_q != IDLE);

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Receive FSM: bit timing, voting, deserialisation and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 2'b00;
            samp_q       <= 2'b00;
            pbit_q       <= 1'b0;
            perr_q       <= 1'b0;
            wait_hi_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            break_det_q <= 1'b0;
            if (sample_tick) begin
                tick_q <= tick_q + TW'(1);
                if (tick_q == MID_M1) samp_q[1] <= rx_s_q;
                if (tick_q == MID)    samp_q[0] <= rx_s_q;
                case (state_q)
                    IDLE: begin
                        tick_q <= '0;
                        bit_q  <= '0;
                        // After a framing error or break the line must be
                        // seen high once before a new start is accepted.
                        if (wait_hi_q) begin
                            if (rx_s_q) wait_hi_q <= 1'b0;
                        end else if (!rx_s_q) begin
                            par_q   <= parity_mode;
                            state_q <= START;
                        end
                    end
                    START: begin
                        if (at_vote && vote) state_q <= IDLE;
                        else if (at_wrap)    state_q <= DATA;
                    end
                    DATA: begin
                        if (at_vote) begin
                            shift_q <= {vote, shift_q[DATA_BITS-1:1]};
                            bit_q   <= bit_q + BW'(1);
                        end
                        if (at_wrap && bit_q == NBITS) begin
                            bit_q   <= '0;
                            state_q <= par_on ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (at_vote) begin
                            pbit_q <= vote;
                            perr_q <= par_bad;
                        end
                        if (at_wrap) state_q <= STOP;
                    end
                    STOP: begin
                        if (at_vote) begin
                            rx_data_q    <= shift_q;
                            rx_valid_q   <= 1'b1;
                            frame_err_q  <= ~vote;
                            parity_err_q <= par_on & perr_q;
                            break_det_q  <= brk;
                            if (!vote) wait_hi_q <= 1'b1;
                            // Leaving at the vote point leaves half a bit of
                            // slack to catch a back-to-back start bit.
                            if (STOP_BITS == 1) state_q <= IDLE;
                        end
                        if (STOP_BITS == 2 && at_wrap) state_q <= STOP2;
                    end
                    STOP2: begin
                        if (at_vote) begin
                            if (!vote) begin
                                frame_err_q <= 1'b1;
                                wait_hi_q   <= 1'b1;
                            end
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm_cfg.sv
// Testbench for uart_rx_fsm_cfg: two configurations (8N1 and 7 data bits with
// two stop bits) driven by a tick-aligned serial sender; a character-level
// model predicts every rx_valid and its status flags.
`timescale 1ns/1ps
module tb_uart_rx_fsm_cfg;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sample_tick = 1'b0;
    logic       rx_a = 1'b1;
    logic       rx_b = 1'b1;
    logic [1:0] mode_a = 2'b00;
    logic [1:0] mode_b = 2'b00;

    logic [7:0] data_a;
    logic       vld_a, perr_a, ferr_a, brk_a, busy_a;
    logic [6:0] data_b;
    logic       vld_b, perr_b, ferr_b, brk_b, busy_b;

    int gap  = 4;
    int tcnt = 0;
    int n_chk  = 0;
    int n_fail = 0;
    int vcnt_a = 0;
    int vcnt_b = 0;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t e_a;
    exp_t e_b;

    uart_rx_fsm_cfg #(.DATA_BITS(8), .OVERSAMPLE(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .rx_in(rx_a), .sample_tick(sample_tick),
        .parity_mode(mode_a), .rx_data(data_a), .rx_valid(vld_a),
        .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a), .busy(busy_a)
    );

    uart_rx_fsm_cfg #(.DATA_BITS(7), .OVERSAMPLE(16), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .rx_in(rx_b), .sample_tick(sample_tick),
        .parity_mode(mode_b), .rx_data(data_b), .rx_valid(vld_b),
        .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    // Sample tick: one clk pulse every 'gap' clocks, changed on the falling edge.
    always @(negedge clk) begin
        tcnt = tcnt + 1;
        if (tcnt >= gap) begin
            sample_tick = 1'b1;
            tcnt = 0;
        end else begin
            sample_tick = 1'b0;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Character-level compare for configuration A.
    always @(negedge clk) begin
        if (!rst) begin
            if (vld_a) begin
                vcnt_a++;
                n_chk++;
                if (qa.size() == 0) begin
                    n_fail++;
                    $display("FAIL a_unexpected_valid: got rx_data 0x%0h, expected no character", data_a);
                end else begin
                    e_a = qa.pop_front();
                    check("a_rx_data", {24'b0, data_a}, {23'b0, e_a.data});
                    check("a_parity_err", {31'b0, perr_a}, {31'b0, e_a.perr});
                    check("a_frame_err", {31'b0, ferr_a}, {31'b0, e_a.ferr});
                    check("a_break_det", {31'b0, brk_a}, {31'b0, e_a.brk});
                end
            end
            check("a_break_without_valid", {31'b0, brk_a & ~vld_a}, 32'd0);
        end
    end

    // Character-level compare for configuration B.
    always @(negedge clk) begin
        if (!rst) begin
            if (vld_b) begin
                vcnt_b++;
                n_chk++;
                if (qb.size() == 0) begin
                    n_fail++;
                    $display("FAIL b_unexpected_valid: got rx_data 0x%0h, expected no character", data_b);
                end else begin
                    e_b = qb.pop_front();
                    check("b_rx_data", {25'b0, data_b}, {23'b0, e_b.data});
                    check("b_parity_err", {31'b0, perr_b}, {31'b0, e_b.perr});
                    check("b_frame_err", {31'b0, ferr_b}, {31'b0, e_b.ferr});
                    check("b_break_det", {31'b0, brk_b}, {31'b0, e_b.brk});
                end
            end
            check("b_break_without_valid", {31'b0, brk_b & ~vld_b}, 32'd0);
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_rx(input int w, input logic v);
        if (w == 0) rx_a = v;
        else        rx_b = v;
    endtask

    task automatic wait_tick();
        do @(posedge clk); while (sample_tick !== 1'b1);
        #1;
    endtask

    task automatic drive_bit(input int w, input logic v, input int goff,
                             input logic chkb, input string nm);
        for (int k = 0; k < OS; k++) begin
            set_rx(w, (k == goff) ? ~v : v);
            if (chkb && k == 12) check(nm, {31'b0, (w == 0) ? busy_a : busy_b}, 32'd1);
            wait_tick();
        end
    endtask

    // Send one character and queue what the receiver must report for it.
    task automatic send(input int w, input logic [8:0] d, input logic [1:0] md,
                        input logic [1:0] md_late, input logic pbit, input logic s1,
                        input logic s2, input int gbit, input int goff,
                        input logic chkb, input int idle);
        int         nb;
        int         ones;
        logic       pon;
        logic       fe;
        logic [8:0] dm;
        exp_t       e;
        nb   = (w == 0) ? 8 : 7;
        dm   = d & ((9'd1 << nb) - 9'd1);
        pon  = (md == 2'b01) || (md == 2'b10);
        ones = $countones(dm) + int'(pbit);
        e.data = dm;
        e.perr = pon && ((md == 2'b10) ? (ones % 2 != 0) : (ones % 2 != 1));
        e.ferr = !s1;
        e.brk  = (dm == 9'd0) && (!pon || !pbit) && !s1;
        fe     = !s1 || (w == 1 && !s2);
        if (w == 0) begin mode_a = md; qa.push_back(e); end
        else        begin mode_b = md; qb.push_back(e); end
        for (int k = 0; k < OS; k++) begin
            set_rx(w, 1'b0);
            if (k == 8) begin
                if (w == 0) mode_a = md_late;
                else        mode_b = md_late;
            end
            if (chkb && k == 12) check("busy_start", {31'b0, (w == 0) ? busy_a : busy_b}, 32'd1);
            wait_tick();
        end
        for (int i = 0; i < nb; i++)
            drive_bit(w, dm[i], (i == gbit) ? goff : -1, chkb, "busy_data");
        if (pon) drive_bit(w, pbit, -1, 1'b0, "");
        drive_bit(w, s1, -1, 1'b0, "");
        if (w == 1) drive_bit(w, s2, -1, 1'b0, "");
        if (w == 0) begin
            check("a_hold_data", {24'b0, data_a}, {23'b0, dm});
            check("a_hold_perr", {31'b0, perr_a}, {31'b0, e.perr});
            check("a_hold_ferr", {31'b0, ferr_a}, {31'b0, fe});
        end else begin
            check("b_hold_data", {25'b0, data_b}, {23'b0, dm});
            check("b_hold_perr", {31'b0, perr_b}, {31'b0, e.perr});
            check("b_hold_ferr", {31'b0, ferr_b}, {31'b0, fe});
        end
        if (chkb) check("busy_after_stop", {31'b0, (w == 0) ? busy_a : busy_b}, 32'd0);
        set_rx(w, 1'b1);
        repeat (idle) wait_tick();
    endtask

    initial begin
        int         pre;
        int         w;
        int         nb;
        int         gb;
        logic [8:0] d;
        logic [1:0] md;
        logic [1:0] ml;
        logic       pb;
        logic       s1;
        logic       s2;

        // Reset state
        repeat (5) @(posedge clk);
        #1;
        check("rst_data_a", {24'b0, data_a}, 32'd0);
        check("rst_valid_a", {31'b0, vld_a}, 32'd0);
        check("rst_perr_a", {31'b0, perr_a}, 32'd0);
        check("rst_ferr_a", {31'b0, ferr_a}, 32'd0);
        check("rst_brk_a", {31'b0, brk_a}, 32'd0);
        check("rst_busy_a", {31'b0, busy_a}, 32'd0);
        check("rst_data_b", {25'b0, data_b}, 32'd0);
        check("rst_busy_b", {31'b0, busy_b}, 32'd0);
        rst = 1'b0;
        repeat (4) wait_tick();

        // 8N1, 0x55, busy tracked through the character
        pre = vcnt_a;
        send(0, 9'h055, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, -1, -1, 1'b1, 4);
        check("t1_data_literal", {24'b0, data_a}, 32'h55);
        check("t1_perr_literal", {31'b0, perr_a}, 32'd0);
        check("t1_ferr_literal", {31'b0, ferr_a}, 32'd0);
        check("t1_one_valid", vcnt_a, pre + 1);

        // Even parity, 0xA3 with parity bit 0 then 1
        send(0, 9'h0A3, 2'b10, 2'b01, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0, 2);
        check("t2_perr0_literal", {31'b0, perr_a}, 32'd0);
        check("t2_data0_literal", {24'b0, data_a}, 32'hA3);
        send(0, 9'h0A3, 2'b10, 2'b00, 1'b1, 1'b1, 1'b1, -1, -1, 1'b0, 2);
        check("t2_perr1_literal", {31'b0, perr_a}, 32'd1);
        check("t2_data1_literal", {24'b0, data_a}, 32'hA3);

        // False start: low for 3 ticks
        pre = vcnt_a;
        mode_a = 2'b00;
        set_rx(0, 1'b0);
        repeat (3) wait_tick();
        set_rx(0, 1'b1);
        repeat (7) wait_tick();
        check("t3_busy_before_vote", {31'b0, busy_a}, 32'd1);
        wait_tick();
        check("t3_busy_after_vote", {31'b0, busy_a}, 32'd0);
        repeat (20) wait_tick();
        check("t3_no_valid", vcnt_a, pre);

        // Framing error with break, line held low, then a clean character
        pre = vcnt_a;
        send(0, 9'h000, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, -1, -1, 1'b0, 0);
        check("t4_ferr_literal", {31'b0, ferr_a}, 32'd1);
        set_rx(0, 1'b0);
        repeat (48) wait_tick();
        check("t4_no_retrigger", vcnt_a, pre + 1);
        set_rx(0, 1'b1);
        repeat (20) wait_tick();
        send(0, 9'h03C, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0, 4);
        check("t4_data_literal", {24'b0, data_a}, 32'h3C);
        check("t4_ferr_clear", {31'b0, ferr_a}, 32'd0);

        // 7 data bits, 2 stop bits: glitch in bit 2, then low second stop
        send(1, 9'h02A, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 2, 9, 1'b0, 4);
        check("t5_glitch_data_literal", {25'b0, data_b}, 32'h2A);
        pre = vcnt_b;
        send(1, 9'h015, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, -1, -1, 1'b0, 6);
        check("t5_stop2_ferr_literal", {31'b0, ferr_b}, 32'd1);
        check("t5_single_valid", vcnt_b, pre + 1);

        // Reset in the middle of the data bits
        set_rx(0, 1'b0);
        repeat (16) wait_tick();
        drive_bit(0, 1'b1, -1, 1'b0, "");
        drive_bit(0, 1'b0, -1, 1'b0, "");
        repeat (5) wait_tick();
        check("t6_busy_pre_reset", {31'b0, busy_a}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_data", {24'b0, data_a}, 32'd0);
        check("t6_rst_valid", {31'b0, vld_a}, 32'd0);
        check("t6_rst_ferr", {31'b0, ferr_a}, 32'd0);
        check("t6_rst_perr", {31'b0, perr_a}, 32'd0);
        check("t6_rst_brk", {31'b0, brk_a}, 32'd0);
        check("t6_rst_busy", {31'b0, busy_a}, 32'd0);
        set_rx(0, 1'b1);
        repeat (4) wait_tick();
        rst = 1'b0;
        repeat (4) wait_tick();

        // Back-to-back characters
        send(0, 9'h081, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0, 0);
        check("t7_first_literal", {24'b0, data_a}, 32'h81);
        send(0, 9'h07E, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, -1, -1, 1'b0, 2);
        check("t7_second_literal", {24'b0, data_a}, 32'h7E);

        // Randomised characters on both configurations
        for (int n = 0; n < 40; n++) begin
            w   = $urandom_range(0, 1);
            nb  = (w == 0) ? 8 : 7;
            gap = $urandom_range(1, 4);
            d   = 9'($urandom);
            if ($urandom_range(0, 5) == 0) d = 9'd0;
            md  = 2'($urandom);
            ml  = 2'($urandom);
            pb  = 1'($urandom);
            s1  = ($urandom_range(0, 7) != 0);
            s2  = (w == 1) ? ($urandom_range(0, 7) != 0) : 1'b1;
            gb  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nb - 1) : -1;
            send(w, d, md, ml, pb, s1, s2, gb, $urandom_range(0, 15), 1'b0,
                 (!s1 || !s2) ? $urandom_range(4, 7) : $urandom_range(0, 3));
        end

        gap = 4;
        repeat (40) wait_tick();
        check("a_pending_at_end", qa.size(), 32'd0);
        check("b_pending_at_end", qb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_fsm_cfg.md
Name: uart_rx_fsm_cfg

Overview:
Parametrised UART receive state machine for the self-defined UART core. It deserialises one asynchronous serial line using an external oversampling tick. Data width, oversampling ratio and stop-bit count are configurable, parity mode is selectable at run time, and each bit is decided by a 3-sample majority vote. It sits between the baud-rate generator and the Rx buffer/FIFO, and reports parity, framing and break conditions per character.

Parameters:
DATA_BITS, 8, data bits per character; legal range 5..9; LSB received first.
OVERSAMPLE, 16, sample ticks per bit; legal values 8 or 16; MID = OVERSAMPLE/2.
STOP_BITS, 1, stop bits checked; legal values 1 or 2.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
rx_in  in  1  raw serial input, asynchronous to clk; idle high.
sample_tick  in  1  one-clk pulse at OVERSAMPLE x baud rate.
parity_mode  in  2  00 none, 01 odd, 10 even, 11 none.
rx_data  out  DATA_BITS  last received character; held until the next rx_valid.
rx_valid  out  1  one-clk pulse when a character completes.
parity_err  out  1  parity error flag for the current rx_data; valid with rx_valid.
frame_err  out  1  stop bit sampled low; valid with rx_valid.
break_det  out  1  one-clk pulse when data, parity and first stop bit are all 0.
busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - All outputs 0.
  - Synchroniser flops 1.
  - State IDLE.
  - Tick counter, bit counter and shift register 0.
- Input conditioning:
  - rx_in passes through a 2-flop synchroniser; rx_s is the synchronised value.
  - All logic below uses rx_s. Logic advances only on cycles with sample_tick = 1.
- Majority vote:
  - Within each bit period, rx_s is sampled at tick counts MID-1, MID and MID+1.
  - The bit value is the majority of the 3 samples and is evaluated at count MID+1.
- States:
  - IDLE: on a tick with rx_s = 0, clear the tick counter, latch parity_mode into par_q, go to START. Config changes after this point are ignored until IDLE.
  - START: count ticks.
    - At MID+1, if the vote = 1 (false start), return to IDLE with no outputs.
    - Otherwise continue.
    - At count OVERSAMPLE-1, wrap the counter to 0 and go to DATA.
  - DATA: at the vote point, shift the bit into the MSB of the shift register (right shift, LSB-first). After DATA_BITS bits, at counter wrap, go to PARITY if par_q is 01 or 10, else STOP.
  - PARITY: at the vote, compute the parity error.
    - Even mode: error = XOR(data, pbit) != 0.
    - Odd mode: error = XOR(data, pbit) != 1.
    - Then go to STOP at wrap.
  - STOP: at the first-stop vote:
    - rx_data <= shift register.
    - rx_valid pulses for exactly 1 clk.
    - frame_err <= ~vote.
    - parity_err <= the computed error, or 0 when parity is off.
    - break_det pulses if all data, parity and stop samples are 0.
  - Leaving STOP:
    - If STOP_BITS = 2, go to STOP2, which checks the second stop bit. A low second stop sets frame_err (sticky until the next rx_valid) but never produces a second rx_valid.
    - Then go to IDLE at the vote point, not at wrap. This allows resynchronisation on a back-to-back start bit.
- Output holding: error flags hold their values until the next rx_valid.
- Error recovery: after frame_err or break, IDLE waits for rx_s = 1 on at least one tick before arming start detection. This prevents break-held-low retriggering.
- Widths:
  - Tick counter is clog2(OVERSAMPLE) bits and wraps naturally.
  - Bit counter is clog2(DATA_BITS+1) bits.
- Corner cases:
  - Ticks arriving on consecutive clks are legal.
  - An asserted reset mid-character aborts immediately to reset values, and no rx_valid is emitted.
  - A glitch shorter than 2 sample ticks during a bit is rejected by the vote.

Test Plan:
- 8N1, OVERSAMPLE 16, tick every 4 clks, send 0x55:
  - rx_valid pulses once with rx_data = 0x55 and both error flags 0.
  - busy stays high from start detection until the stop vote.
- Even parity, send 0xA3 with pbit 0 then with pbit 1:
  - First character: parity_err = 0.
  - Second character: parity_err = 1.
  - Both characters: rx_data = 0xA3.
- False start: rx_in low for 3 ticks, then high:
  - Returns to IDLE.
  - No rx_valid.
  - busy drops within 1 tick after MID+1.
- Framing and break:
  - 0x00 with stop low: rx_valid, frame_err = 1, break_det pulses.
  - Holding rx low produces no further rx_valid until rx returns high, then 0x3C is received cleanly.
- Glitch, STOP_BITS = 2, DATA_BITS = 7:
  - A 1-tick glitch at count MID inside bit 2 of 0x2A still yields rx_data = 0x2A.
  - A low second stop bit sets frame_err with a single rx_valid.
- Reset and back-to-back:
  - Assert rst mid-DATA: all outputs return to 0 immediately.
  - Afterwards, two back-to-back characters 0x81, 0x7E are both received in order.
